// File: rtl/opc_arb_pkg.sv
// Shared definitions for the tristate bus arbiter: FSM state encoding and width helper.
package opc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) is 0, so callers guard single-value counters themselves.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tbuf_bus_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after the pointer, wrapping modulo N.
module rr_pick
  import opc_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic [N-1:0]          onehot,
  output logic [clog2(N)-1:0]   idx,
  output logic                  valid
);

  localparam int unsigned OW = clog2(N);

  int unsigned cand;

  // Scan N candidates starting at ptr; the first hit wins and masks later ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!valid && req[OW'(cand)]) begin
        valid            = 1'b1;
        idx              = OW'(cand);
        onehot[OW'(cand)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner selection for a shared tristate net with break-before-make dead time
// and an optional maximum hold time per ownership.
module tbuf_bus_arbiter
  import opc_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned DEADTIME = 1,
  parameter int unsigned MAXHOLD  = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N-1:0]        REQ,
  output logic [N-1:0]        GNT,
  output logic [clog2(N)-1:0] OWNER,
  output logic                BUSY,
  output logic                TIMEOUT
);

  localparam int unsigned OW = clog2(N);
  // Hold counter must still be at least one bit wide when the timeout is disabled.
  localparam int unsigned HW = (MAXHOLD == 0) ? 1 : clog2(MAXHOLD + 1);
  localparam int unsigned DW = clog2(DEADTIME + 1);

  state_t          state;
  logic [OW-1:0]   ptr;
  logic [HW-1:0]   hold;
  logic [DW-1:0]   dead;

  logic [N-1:0]    pick_onehot;
  logic [OW-1:0]   pick_idx;
  logic            pick_valid;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (REQ),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Arbitration FSM; grants only ever rise from an all-low cycle, so GNT stays one-hot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      ptr     <= '0;
      hold    <= '0;
      dead    <= '0;
      GNT     <= '0;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            GNT   <= pick_onehot;
            OWNER <= pick_idx;
            BUSY  <= 1'b1;
            hold  <= HW'(1);
            state <= GRANT;
          end
        end

        GRANT: begin
          if (!REQ[OWNER] || (MAXHOLD != 0 && hold == HW'(MAXHOLD))) begin
            // Voluntary release wins over the timeout when both coincide.
            TIMEOUT <= REQ[OWNER];
            GNT     <= '0;
            OWNER   <= '0;
            BUSY    <= 1'b0;
            ptr     <= (OWNER == OW'(N - 1)) ? '0 : OWNER + OW'(1);
            dead    <= DW'(DEADTIME);
            state   <= TURN;
          end else begin
            hold <= hold + HW'(1);
          end
        end

        TURN: begin
          if (dead == DW'(1)) begin
            if (pick_valid) begin
              GNT   <= pick_onehot;
              OWNER <= pick_idx;
              BUSY  <= 1'b1;
              hold  <= HW'(1);
              state <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            dead <= dead - DW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Scoreboard bench: two arbiter configurations share one stimulus stream; an integer-level
// ownership model predicts every post-edge output and a monitor compares one cycle later.
module tb_tbuf_bus_arbiter;

  localparam int N_A = 4;
  localparam int DT_A = 1;
  localparam int MH_A = 8;
  localparam int N_B = 5;
  localparam int DT_B = 3;
  localparam int MH_B = 3;

  typedef struct {
    int owner;   // -1 when nobody owns the bus
    int cycles;  // grant cycles the owner has had so far
    int gap;     // dead cycles still to run before arbitration may happen
    int ptr;     // requester searched first at the next arbitration
  } mdl_t;

  typedef struct {
    int gnt;
    int owner;
    int busy;
    int to;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N_A-1:0] req_a;
  logic [N_A-1:0] gnt_a;
  logic [1:0]     owner_a;
  logic           busy_a;
  logic           to_a;
  logic [N_B-1:0] req_b;
  logic [N_B-1:0] gnt_b;
  logic [2:0]     owner_b;
  logic           busy_b;
  logic           to_b;

  int   n_checks = 0;
  int   n_fail = 0;
  mdl_t ma;
  mdl_t mb;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  tbuf_bus_arbiter #(.N(N_A), .DEADTIME(DT_A), .MAXHOLD(MH_A)) dut_a (
    .CLK(clk), .RESET(rst), .REQ(req_a), .GNT(gnt_a),
    .OWNER(owner_a), .BUSY(busy_a), .TIMEOUT(to_a)
  );

  tbuf_bus_arbiter #(.N(N_B), .DEADTIME(DT_B), .MAXHOLD(MH_B)) dut_b (
    .CLK(clk), .RESET(rst), .REQ(req_b), .GNT(gnt_b),
    .OWNER(owner_b), .BUSY(busy_b), .TIMEOUT(to_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of bus ownership, expressed as who owns it and for how long.
  function automatic void mstep(inout mdl_t m, output exp_t e, input int req,
                                input int n, input int dt, input int mh);
    int to;
    to = 0;
    if (m.owner >= 0) begin
      if (((req >> m.owner) & 1) == 0 || (mh != 0 && m.cycles == mh)) begin
        to      = ((req >> m.owner) & 1);
        m.ptr   = (m.owner + 1) % n;
        m.owner = -1;
        m.gap   = dt;
      end else begin
        m.cycles++;
      end
    end else if (m.gap > 1) begin
      m.gap--;
    end else begin
      m.gap = 0;
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m.ptr + k) % n;
        if (m.owner < 0 && ((req >> c) & 1) == 1) begin
          m.owner  = c;
          m.cycles = 1;
        end
      end
    end
    e.gnt   = (m.owner >= 0) ? (1 << m.owner) : 0;
    e.owner = (m.owner >= 0) ? m.owner : 0;
    e.busy  = (m.owner >= 0) ? 1 : 0;
    e.to    = to;
  endfunction

  task automatic model_reset();
    ma = '{-1, 0, 0, 0};
    mb = '{-1, 0, 0, 0};
  endtask

  // Apply requests ahead of the next rising edge and queue the predicted response.
  task automatic drive(input int ra, input int rb);
    exp_t e;
    @(negedge clk);
    req_a = N_A'(ra);
    req_b = N_B'(rb);
    mstep(ma, e, ra & ((1 << N_A) - 1), N_A, DT_A, MH_A);
    qa.push_back(e);
    mstep(mb, e, rb & ((1 << N_B) - 1), N_B, DT_B, MH_B);
    qb.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_a(input string nm, input int g, input int o, input int b, input int t);
    chk({nm, "_gnt"}, int'(gnt_a), g);
    chk({nm, "_owner"}, int'(owner_a), o);
    chk({nm, "_busy"}, int'(busy_a), b);
    chk({nm, "_timeout"}, int'(to_a), t);
  endtask

  task automatic chk_b(input string nm, input int g, input int o, input int b, input int t);
    chk({nm, "_gnt"}, int'(gnt_b), g);
    chk({nm, "_owner"}, int'(owner_b), o);
    chk({nm, "_busy"}, int'(busy_b), b);
    chk({nm, "_timeout"}, int'(to_b), t);
  endtask

  // Raise reset between edges and confirm outputs clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    #1;
    chk_a("async_reset_a", 0, 0, 0, 0);
    chk_b("async_reset_b", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Scoreboard monitor: compare each queued prediction just after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("onehot_a", int'($onehot0(gnt_a)), 1);
      chk("onehot_b", int'($onehot0(gnt_b)), 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        chk("sb_a_gnt", int'(gnt_a), e.gnt);
        chk("sb_a_owner", int'(owner_a), e.owner);
        chk("sb_a_busy", int'(busy_a), e.busy);
        chk("sb_a_timeout", int'(to_a), e.to);
      end
      if (qb.size() != 0) begin
        e = qb.pop_front();
        chk("sb_b_gnt", int'(gnt_b), e.gnt);
        chk("sb_b_owner", int'(owner_b), e.owner);
        chk("sb_b_busy", int'(busy_b), e.busy);
        chk("sb_b_timeout", int'(to_b), e.to);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ra;
    int rb;
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    model_reset();
    do_reset();

    // Owner 2 on A, then reset mid-grant.
    drive(4, 0);
    drive(4, 0);
    after_edge();
    chk("pre_reset_gnt_a", int'(gnt_a), 4);
    do_reset();

    // All requesting: 8-cycle ownerships rotating 0,1,2,3,0 with one dead cycle each.
    for (int e = 0; e < 45; e++) begin
      drive(15, 0);
      after_edge();
      if (e % 9 == 8) chk_a("rr_full", 0, 0, 0, 1);
      else chk_a("rr_full", 1 << ((e / 9) % 4), (e / 9) % 4, 1, 0);
    end
    do_reset();

    // Single requester drops before edge 5; TURN pulse on B must not be granted.
    for (int e = 0; e < 10; e++) begin
      drive((e < 5) ? 2 : 0, (e < 2) ? 1 : (e == 3) ? 4 : (e == 9) ? 8 : 0);
      after_edge();
      if (e < 5) chk_a("short_own", 2, 1, 1, 0);
      else chk_a("short_own", 0, 0, 0, 0);
      if (e < 2) chk_b("turn_pulse", 1, 0, 1, 0);
      else if (e < 9) chk_b("turn_pulse", 0, 0, 0, 0);
      else chk_b("turn_pulse", 8, 3, 1, 0);
    end
    do_reset();

    // A: REQ[0] drops exactly at its 8th edge -> voluntary. B: 3-cycle dead time.
    for (int e = 0; e < 10; e++) begin
      drive((e < 8) ? 3 : 2, (e < 2) ? 3 : 2);
      after_edge();
      if (e < 8) chk_a("drop_at_limit", 1, 0, 1, 0);
      else if (e == 8) chk_a("drop_at_limit", 0, 0, 0, 0);
      else chk_a("drop_at_limit", 2, 1, 1, 0);
      if (e < 2) chk_b("dead3", 1, 0, 1, 0);
      else if (e < 5) chk_b("dead3", 0, 0, 0, 0);
      else if (e < 8) chk_b("dead3", 2, 1, 1, 0);
    end
    do_reset();

    // Randomised traffic with sticky requests, one asynchronous reset midway.
    ra = 0;
    rb = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      ra = (ra ^ int'($urandom & $urandom)) & ((1 << N_A) - 1);
      rb = (rb ^ int'($urandom & $urandom)) & ((1 << N_B) - 1);
      drive(ra, rb);
    end

    drive(0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
